program_loader: RTL

- Boot-time program loader directly upstream of the CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes those words to instruction memory at consecutive byte addresses 0, 4, 8, ….
- Holds the CPU out of execution (cpu_run low) until the whole image has been received and its checksum verified.

---
 rtl/program_loader_if.sv | 22 ++
 rtl/program_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Byte-stream ingress and instruction-memory write port of the boot program loader.
interface program_loader_if;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        im_wren;
   logic [31:0] im_waddr;
   logic [31:0] im_wdata;
   logic        cpu_run;
   logic        load_error;

   modport master (
      output start, byte_valid, byte_data,
      input  byte_ready, im_wren, im_waddr, im_wdata, cpu_run, load_error
   );

   modport slave (
      input  start, byte_valid, byte_data,
      output byte_ready, im_wren, im_waddr, im_wdata, cpu_run, load_error
   );
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte image into 32-bit
// instruction-memory writes and releases the CPU only after the checksum matches.
module program_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   program_loader_if.slave  bus
);

   localparam int unsigned CNT_W     = 16;
   localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_LEN0 = 3'd0,
      S_LEN1 = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_e;

   state_e                  state_q, state_d;
   logic [1:0]              byte_cnt_q, byte_cnt_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [7:0]              csum_q, csum_d;
   logic [31:0]             word_q, word_d;
   logic                    im_wren_q, im_wren_d;
   logic [31:0]             im_waddr_q, im_waddr_d;
   logic [31:0]             im_wdata_q, im_wdata_d;

   logic                    accepting;
   logic                    accept;
   logic [CNT_W-1:0]        len_full;
   logic                    last_word;

   // Stream is only taken while parsing, never in the start cycle or under reset.
   assign accepting      = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                           (state_q == S_DATA) || (state_q == S_CSUM);
   assign bus.byte_ready = rst && !bus.start && accepting;
   assign accept         = bus.byte_valid && bus.byte_ready;

   assign bus.im_wren    = im_wren_q;
   assign bus.im_waddr   = im_waddr_q;
   assign bus.im_wdata   = im_wdata_q;
   assign bus.cpu_run    = (state_q == S_DONE);
   assign bus.load_error = (state_q == S_ERR);

   assign len_full  = {bus.byte_data, count_q[7:0]};
   assign last_word = (32'(idx_q) == (32'(count_q) - 32'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_LEN0;
         byte_cnt_q <= 2'd0;
         idx_q      <= '0;
         count_q    <= '0;
         csum_q     <= 8'd0;
         word_q     <= 32'd0;
         im_wren_q  <= 1'b0;
         im_waddr_q <= 32'd0;
         im_wdata_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         idx_q      <= idx_d;
         count_q    <= count_d;
         csum_q     <= csum_d;
         word_q     <= word_d;
         im_wren_q  <= im_wren_d;
         im_waddr_q <= im_waddr_d;
         im_wdata_q <= im_wdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      idx_d      = idx_q;
      count_d    = count_q;
      csum_d     = csum_q;
      word_d     = word_q;
      im_wren_d  = 1'b0;
      im_waddr_d = im_waddr_q;
      im_wdata_d = im_wdata_q;

      if (bus.start) begin
         // A write registered last cycle still drains; everything else restarts.
         state_d    = S_LEN0;
         byte_cnt_d = 2'd0;
         idx_d      = '0;
         count_d    = '0;
         csum_d     = 8'd0;
         word_d     = 32'd0;
      end else if (accept) begin
         csum_d = csum_q ^ bus.byte_data;
         unique case (state_q)
            S_LEN0: begin
               count_d[7:0] = bus.byte_data;
               state_d      = S_LEN1;
            end
            S_LEN1: begin
               count_d = len_full;
               if (len_full == '0) begin
                  state_d = S_CSUM;
               end else if (32'(len_full) > MAX_WORDS) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               word_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  im_wren_d  = 1'b1;
                  im_waddr_d = 32'(idx_q) << 2;
                  im_wdata_d = {bus.byte_data, word_q[23:0]};
                  if (last_word) begin
                     state_d = S_CSUM;
                  end else begin
                     idx_d = idx_q + ADDR_WIDTH'(1);
                  end
               end
            end
            S_CSUM: begin
               // The checksum byte itself is not folded into the accumulator.
               csum_d  = csum_q;
               state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
